// File: rtl/vec_alu_lanes.sv
// Multi-lane vector ALU with valid/ready flow control, 1-cycle latency,
// optional signed saturation, per-vector sticky overflow and sum reduction.
module vec_alu_lanes #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 8,
  parameter int ACC_EXT   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [5:0]                  funct,
  input  logic [$clog2(DATA_W)-1:0]   shamt,
  input  logic                        sat_en,
  input  logic                        red_en,
  input  logic [LANES*DATA_W-1:0]     src1,
  input  logic [LANES*DATA_W-1:0]     src2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [LANES*DATA_W-1:0]     result,
  output logic [LANES-1:0]            lane_ovf,
  output logic                        vec_ovf,
  output logic                        red_valid,
  output logic [DATA_W+ACC_EXT-1:0]   red_sum,
  output logic                        len_err
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int ACC_W = DATA_W + ACC_EXT;

  localparam logic [5:0] F_NOP  = 6'h00;
  localparam logic [5:0] F_SLL  = 6'h01;
  localparam logic [5:0] F_SRL  = 6'h03;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_ABS  = 6'h30;

  localparam logic [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [5:0]                     funct_q;
  logic [SH_W-1:0]                shamt_q;
  logic                           sat_q, red_q;
  logic [5:0]                     f_eff;
  logic [SH_W-1:0]                sh_eff;
  logic                           sat_eff, red_eff;
  logic                           accept, first_beat, forced_end, vec_end;
  logic [LANES-1:0][DATA_W-1:0]   res_d;
  logic [LANES-1:0]               ovf_d;
  logic [ACC_W-1:0]               beat_sum, acc_d, acc_q;
  logic                           out_valid_q, out_last_q, vec_ovf_q, red_valid_q, len_err_q;
  logic [LANES*DATA_W-1:0]        result_q;
  logic [LANES-1:0]               lane_ovf_q;
  logic [ACC_W-1:0]               red_sum_q;

  // Returns {overflow, result}; the extra bit on the operands gives the true sign.
  function automatic logic [DATA_W:0] lane_op(input logic [5:0] f, input logic [SH_W-1:0] sh,
                                              input logic sat, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] ax, bx, s, mag;
    logic [DATA_W-1:0]      r;
    logic                   ovf;
    ax  = $signed({a[DATA_W-1], a});
    bx  = $signed({b[DATA_W-1], b});
    s   = '0;
    mag = '0;
    r   = '0;
    ovf = 1'b0;
    case (f)
      F_ADD, F_SUB: begin
        s   = (f == F_ADD) ? ax + bx : ax - bx;
        ovf = s[DATA_W] ^ s[DATA_W-1];
        r   = (ovf && sat) ? (s[DATA_W] ? S_MIN : S_MAX) : s[DATA_W-1:0];
      end
      F_ABS: begin
        s   = ax - bx;
        mag = s[DATA_W] ? -s : s;
        ovf = mag[DATA_W] | mag[DATA_W-1];
        r   = (ovf && sat) ? S_MAX : mag[DATA_W-1:0];
      end
      F_MULT: r = a * b;
      F_AND:  r = a & b;
      F_OR:   r = a | b;
      F_XOR:  r = a ^ b;
      F_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLL:  r = b << sh;
      F_SRL:  r = $signed(b) >>> sh;
      F_NOP:  r = '0;
      default: r = '0;
    endcase
    return {ovf, r};
  endfunction

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = (state_q == IDLE);
  assign f_eff      = first_beat ? funct  : funct_q;
  assign sh_eff     = first_beat ? shamt  : shamt_q;
  assign sat_eff    = first_beat ? sat_en : sat_q;
  assign red_eff    = first_beat ? red_en : red_q;
  assign forced_end = !in_last && ((MAX_BEATS == 1) || (state_q == RUN && cnt_q == LAST_CNT));
  assign vec_end    = in_last || forced_end;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (vec_end) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    res_d    = '0;
    ovf_d    = '0;
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      {ovf_d[i], res_d[i]} = lane_op(f_eff, sh_eff, sat_eff,
                                     src1[i*DATA_W +: DATA_W], src2[i*DATA_W +: DATA_W]);
      beat_sum = beat_sum + {{ACC_EXT{res_d[i][DATA_W-1]}}, res_d[i]};
    end
    acc_d = (first_beat ? '0 : acc_q) + (red_eff ? beat_sum : '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct_q     <= '0;
      shamt_q     <= '0;
      sat_q       <= 1'b0;
      red_q       <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      result_q    <= '0;
      lane_ovf_q  <= '0;
      vec_ovf_q   <= 1'b0;
      red_valid_q <= 1'b0;
      red_sum_q   <= '0;
      len_err_q   <= 1'b0;
    end else begin
      red_valid_q <= 1'b0;
      if (accept) begin
        if (first_beat) begin
          funct_q <= funct;
          shamt_q <= shamt;
          sat_q   <= sat_en;
          red_q   <= red_en;
        end
        out_valid_q <= 1'b1;
        out_last_q  <= vec_end;
        len_err_q   <= forced_end;
        result_q    <= res_d;
        lane_ovf_q  <= ovf_d;
        vec_ovf_q   <= (first_beat ? 1'b0 : vec_ovf_q) | (|ovf_d);
        acc_q       <= acc_d;
        // The pulse is tied to acceptance, so a stalled final beat never repeats it.
        if (vec_end && red_eff) begin
          red_valid_q <= 1'b1;
          red_sum_q   <= acc_d;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign result    = result_q;
  assign lane_ovf  = lane_ovf_q;
  assign vec_ovf   = vec_ovf_q;
  assign red_valid = red_valid_q;
  assign red_sum   = red_sum_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_vec_alu_lanes.sv
// Self-checking bench for vec_alu_lanes: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_vec_alu_lanes;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int MB = 8;
  localparam int AE = 8;
  localparam int AW = DW + AE;

  localparam logic [5:0] F_NOP  = 6'h00;
  localparam logic [5:0] F_SLL  = 6'h01;
  localparam logic [5:0] F_SRL  = 6'h03;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_ABS  = 6'h30;

  logic              clk, rst, in_valid, in_ready, in_last, sat_en, red_en;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [LN*DW-1:0]  src1, src2, result;
  logic              out_valid, out_ready, out_last, vec_ovf, red_valid, len_err;
  logic [LN-1:0]     lane_ovf;
  logic [AW-1:0]     red_sum;

  vec_alu_lanes #(.DATA_W(DW), .LANES(LN), .MAX_BEATS(MB), .ACC_EXT(AE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .funct(funct), .shamt(shamt), .sat_en(sat_en), .red_en(red_en), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .result(result),
    .lane_ovf(lane_ovf), .vec_ovf(vec_ovf), .red_valid(red_valid), .red_sum(red_sum),
    .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: beats taken in the current vector and vector-wide controls.
  int              m_cnt;
  logic [5:0]      m_funct;
  logic [4:0]      m_shamt;
  bit              m_sat, m_red, m_vovf;
  longint          m_acc;
  bit              e_valid, e_last, e_len_err, e_vovf, e_red_valid;
  logic [LN*DW-1:0] e_res;
  logic [LN-1:0]   e_ovf;
  longint          e_red_sum;

  function automatic logic [LN*DW-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                             input logic [DW-1:0] l2, input logic [DW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Exact-integer reference: compute the true value, then decide overflow/clamp/wrap.
  function automatic void ref_lane(input logic [5:0] f, input int sh, input bit sat,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output logic [DW-1:0] r, output bit o);
    longint sa, sb, t, maxv, minv;
    maxv = (longint'(1) << (DW-1)) - 1;
    minv = -(longint'(1) << (DW-1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = 1'b0;
    case (f)
      F_ADD:  t = sa + sb;
      F_SUB:  t = sa - sb;
      F_ABS:  begin t = sa - sb; if (t < 0) t = -t; end
      F_MULT: t = sa * sb;
      F_AND:  t = sa & sb;
      F_OR:   t = sa | sb;
      F_XOR:  t = sa ^ sb;
      F_SLT:  t = (sa < sb) ? 1 : 0;
      F_SLL:  t = sb << sh;
      F_SRL:  t = sb >>> sh;
      default: t = 0;
    endcase
    if (f == F_ADD || f == F_SUB) o = (t > maxv) || (t < minv);
    if (f == F_ABS) o = (t > maxv);
    if (o && sat) t = (t > maxv) ? maxv : minv;
    r = t[DW-1:0];
  endfunction

  task automatic model_accept();
    logic [DW-1:0]  r;
    logic [AW-1:0]  wrapped;
    bit             o;
    longint         sum;
    if (m_cnt == 0) begin
      m_funct = funct; m_shamt = shamt; m_sat = sat_en; m_red = red_en;
      m_vovf = 1'b0; m_acc = 0;
    end
    sum = 0;
    for (int i = 0; i < LN; i++) begin
      ref_lane(m_funct, m_shamt, m_sat, src1[i*DW +: DW], src2[i*DW +: DW], r, o);
      e_res[i*DW +: DW] = r;
      e_ovf[i] = o;
      sum += longint'($signed(r));
    end
    m_cnt++;
    m_vovf = m_vovf | (|e_ovf);
    if (m_red) begin
      wrapped = AW'(m_acc + sum);
      m_acc = longint'($signed(wrapped));
    end
    e_valid     = 1'b1;
    e_last      = in_last || (m_cnt == MB);
    e_len_err   = !in_last && (m_cnt == MB);
    e_vovf      = m_vovf;
    e_red_valid = e_last && m_red;
    if (e_red_valid) e_red_sum = m_acc;
    if (e_last) m_cnt = 0;
  endtask

  task automatic tick_model();
    if (in_valid && (!e_valid || out_ready)) begin
      model_accept();
    end else begin
      e_red_valid = 1'b0;
      if (out_ready) e_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0; m_vovf = 1'b0; m_acc = 0;
    e_valid = 1'b0; e_last = 1'b0; e_len_err = 1'b0; e_vovf = 1'b0; e_red_valid = 1'b0;
    e_res = '0; e_ovf = '0; e_red_sum = 0;
  endtask

  task automatic set_beat(input logic [5:0] f, input int sh, input bit sat, input bit red,
                          input bit last, input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
    in_valid = 1'b1; funct = f; shamt = 5'(sh); sat_en = sat; red_en = red;
    in_last = last; src1 = a; src2 = b;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_last, result, lane_ovf, vec_ovf, red_valid, red_sum, len_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b l=%b r=%h o=%b vo=%b rv=%b rs=%h le=%b, expected all 0",
               out_valid, out_last, result, lane_ovf, vec_ovf, red_valid, red_sum, len_err);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_reduce();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_beat(F_ADD, 0, 0, 1, k == 1, pack4(1, 2, 3, 4), pack4(5, 5, 5, 5));
      tick_model();
      n_checks++;
      if (result !== pack4(6, 7, 8, 9)) begin
        n_errors++; $display("FAIL add_result beat%0d: got %h expected %h", k, result, pack4(6, 7, 8, 9));
      end
      n_checks++;
      if ({out_valid, out_last, red_valid} !== {1'b1, k == 1, k == 1}) begin
        n_errors++; $display("FAIL add_flags beat%0d: got v/l/rv=%b%b%b", k, out_valid, out_last, red_valid);
      end
    end
    n_checks++;
    if (red_sum !== AW'(60) || vec_ovf !== 1'b0 || len_err !== 1'b0) begin
      n_errors++; $display("FAIL add_reduce: got red_sum=%0d vec_ovf=%b len_err=%b expected 60 0 0",
                           red_sum, vec_ovf, len_err);
    end
    in_valid = 1'b0;
    tick_model();
    n_checks++;
    if (red_valid !== 1'b0 || red_sum !== AW'(60)) begin
      n_errors++; $display("FAIL add_pulse_hold: got red_valid=%b red_sum=%0d expected 0 60", red_valid, red_sum);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] exp0;
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp0 = (s == 1) ? 32'h7FFFFFFF : 32'h80000000;
      set_beat(F_ADD, 0, s, 0, 1, pack4(32'h7FFFFFFF, 0, -5, 10), pack4(1, 0, 3, 20));
      tick_model();
      n_checks++;
      if (result !== pack4(exp0, 0, -2, 30)) begin
        n_errors++; $display("FAIL sat_result sat=%0d: got %h expected %h", s, result, pack4(exp0, 0, -2, 30));
      end
      n_checks++;
      if ({lane_ovf, vec_ovf, out_last} !== {4'b0001, 1'b1, 1'b1}) begin
        n_errors++; $display("FAIL sat_ovf sat=%0d: got lane_ovf=%b vec_ovf=%b last=%b", s, lane_ovf, vec_ovf, out_last);
      end
    end
  endtask

  task automatic test_ops();
    logic [5:0]    t_f [5];
    int            t_sh[5];
    logic [DW-1:0] t_a [5], t_b[5], t_e[5];
    t_f = '{F_ABS, F_SRL, F_SLT, F_MULT, 6'h3F};
    t_sh = '{0, 4, 0, 0, 0};
    t_a = '{-3, 0, -1, 32'h10000, 32'h1234};
    t_b = '{4, 32'hF0000000, 1, 32'h10000, 32'h5678};
    t_e = '{7, 32'hFF000000, 1, 0, 0};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_beat(t_f[k], t_sh[k], 0, 0, 1, {4{t_a[k]}}, {4{t_b[k]}});
      tick_model();
      n_checks++;
      if (result !== {4{t_e[k]}} || lane_ovf !== 4'b0 || red_valid !== 1'b0) begin
        n_errors++; $display("FAIL op_%h: got result=%h ovf=%b rv=%b expected lanes %h ovf 0 rv 0",
                             t_f[k], result, lane_ovf, red_valid, t_e[k]);
      end
    end
  endtask

  function automatic logic [LN*DW-1:0] bp_exp(input int k);
    return pack4(10*k + 1, 10*k + 2, 10*k + 3, 10*k + 4);
  endfunction

  task automatic test_back_pressure();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_beat(k == 0 ? F_ADD : F_SUB, 0, 0, k == 0, 0, bp_exp(k) - pack4(1, 1, 1, 1) + pack4(0, 0, 0, 0),
               pack4(1, 1, 1, 1));
      src1 = pack4(10*k, 10*k + 1, 10*k + 2, 10*k + 3);
      tick_model();
      n_checks++;
      if (result !== bp_exp(k)) begin
        n_errors++; $display("FAIL bp_beat%0d: got %h expected %h", k, result, bp_exp(k));
      end
    end
    set_beat(F_XOR, 3, 1, 0, 0, pack4(20, 21, 22, 23), pack4(1, 1, 1, 1));
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick_model();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== bp_exp(1) || red_valid !== 1'b0) begin
        n_errors++; $display("FAIL bp_hold cycle%0d: got in_ready=%b out_valid=%b result=%h expected 0 1 %h",
                             c, in_ready, out_valid, result, bp_exp(1));
      end
    end
    out_ready = 1'b1;
    tick_model();
    n_checks++;
    if (result !== bp_exp(2) || out_last !== 1'b0) begin
      n_errors++; $display("FAIL bp_beat2: got %h last=%b expected %h last=0", result, out_last, bp_exp(2));
    end
    set_beat(F_AND, 0, 0, 0, 1, pack4(30, 31, 32, 33), pack4(1, 1, 1, 1));
    tick_model();
    n_checks++;
    if (result !== bp_exp(3) || {out_last, red_valid} !== 2'b11 || red_sum !== AW'(280)) begin
      n_errors++; $display("FAIL bp_beat3: got %h last=%b rv=%b sum=%0d expected %h 1 1 280",
                           result, out_last, red_valid, red_sum, bp_exp(3));
    end
    in_valid = 1'b0;
    tick_model();
  endtask

  task automatic test_max_beats();
    longint exp_sum;
    out_ready = 1'b1;
    exp_sum = 7*8 - 64'sd2147483648 + 6;
    for (int k = 0; k < MB; k++) begin
      set_beat(F_ADD, 0, 0, 1, 0, (k == 3) ? pack4(32'h7FFFFFFF, 1, 1, 1) : pack4(1, 1, 1, 1),
               pack4(1, 1, 1, 1));
      tick_model();
      n_checks++;
      if ({out_last, len_err} !== {k == MB-1, k == MB-1}) begin
        n_errors++; $display("FAIL maxb_flags beat%0d: got last=%b len_err=%b", k, out_last, len_err);
      end
    end
    n_checks++;
    if (vec_ovf !== 1'b1 || red_valid !== 1'b1 || longint'($signed(red_sum)) !== exp_sum) begin
      n_errors++; $display("FAIL maxb_end: got vec_ovf=%b rv=%b sum=%0d expected 1 1 %0d",
                           vec_ovf, red_valid, $signed(red_sum), exp_sum);
    end
    set_beat(F_ADD, 0, 0, 1, 1, pack4(2, 2, 2, 2), pack4(3, 3, 3, 3));
    tick_model();
    n_checks++;
    if ({vec_ovf, len_err, out_last, red_valid} !== 4'b0011 || red_sum !== AW'(20)) begin
      n_errors++; $display("FAIL maxb_next: got vo=%b le=%b l=%b rv=%b sum=%0d expected 0 0 1 1 20",
                           vec_ovf, len_err, out_last, red_valid, red_sum);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_beat(F_ADD, 0, 0, 1, 0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
      tick_model();
    end
    do_reset();
    n_checks++;
    if ({out_valid, out_last, result, lane_ovf, vec_ovf, red_valid, red_sum, len_err} !== '0) begin
      n_errors++; $display("FAIL rstmid_outputs: got v=%b rv=%b rs=%h r=%h expected all 0",
                           out_valid, red_valid, red_sum, result);
    end
    set_beat(F_SUB, 0, 0, 1, 1, pack4(10, 20, 30, 40), pack4(1, 2, 3, 4));
    tick_model();
    n_checks++;
    if (result !== pack4(9, 18, 27, 36) || {out_last, red_valid, len_err} !== 3'b110 || red_sum !== AW'(90)) begin
      n_errors++; $display("FAIL rstmid_next: got %h l=%b rv=%b le=%b sum=%0d expected %h 1 1 0 90",
                           result, out_last, red_valid, len_err, red_sum, pack4(9, 18, 27, 36));
    end
    in_valid = 1'b0;
    tick_model();
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom % 6)
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'h0;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [5:0] fl[12];
    int  g_left = 0;
    bit  g_force = 1'b0, g_have = 1'b0, acc;
    fl = '{F_NOP, F_ADD, F_SUB, F_MULT, F_AND, F_OR, F_XOR, F_SLT, F_SLL, F_SRL, F_ABS, 6'h3F};
    for (int c = 0; c < 2000; c++) begin
      if (g_left == 0) begin
        g_force = ($urandom % 6) == 0;
        g_left  = g_force ? MB : int'($urandom_range(1, MB));
      end
      if (!g_have) begin
        set_beat(fl[$urandom % 12], $urandom % 32, $urandom % 2, $urandom % 2, !g_force && g_left == 1,
                 pack4(rand_word(), rand_word(), rand_word(), rand_word()),
                 pack4(rand_word(), rand_word(), rand_word(), rand_word()));
        g_have = 1'b1;
      end
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      #1;
      n_checks++;
      if (in_ready !== (!e_valid || out_ready)) begin
        n_errors++; $display("FAIL rnd_in_ready cycle%0d: got %b expected %b", c, in_ready, !e_valid || out_ready);
      end
      acc = in_valid && (!e_valid || out_ready);
      tick_model();
      if (acc) begin g_have = 1'b0; g_left--; end
      n_checks++;
      if (out_valid !== e_valid || red_valid !== e_red_valid || longint'($signed(red_sum)) !== e_red_sum) begin
        n_errors++; $display("FAIL rnd_ctrl cycle%0d: got v=%b rv=%b sum=%0d expected %b %b %0d",
                             c, out_valid, red_valid, $signed(red_sum), e_valid, e_red_valid, e_red_sum);
      end
      if (e_valid) begin
        n_checks++;
        if (result !== e_res || lane_ovf !== e_ovf || {out_last, len_err, vec_ovf} !== {e_last, e_len_err, e_vovf}) begin
          n_errors++; $display("FAIL rnd_beat cycle%0d: got %h ovf=%b l/le/vo=%b%b%b expected %h ovf=%b %b%b%b",
                               c, result, lane_ovf, out_last, len_err, vec_ovf, e_res, e_ovf, e_last, e_len_err, e_vovf);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick_model();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; funct = '0; shamt = '0; sat_en = 1'b0;
    red_en = 1'b0; src1 = '0; src2 = '0; out_ready = 1'b1;
    test_reset();
    test_add_reduce();
    test_saturation();
    test_ops();
    test_back_pressure();
    test_max_beats();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
